data_mem_delay: RTL and testbench

Multi-cycle data memory for the M stage of the five-stage MIPS pipeline: the responder side of the load-latency stall that the hazard unit applies. A load is serviced in exactly MEM_DELAY stall cycles and its data is presented one cycle later. During that time `busy` tells the hazard logic to freeze the F/D/E/M/W stages. Stores complete in a single cycle with no stall.

---
 rtl/data_mem_delay.sv | 121 ++++++++++++
 tb/tb_data_mem_delay.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_delay.sv
// M-stage data memory with a configurable load stall. Loads hold `busy` for
// MEM_DELAY cycles, then present registered data with a one-cycle `done`.
module data_mem_delay #(
   parameter int MEM_DELAY = 3,
   parameter int ADDR_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadm,
   input  logic        memwritem,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [3:0] LP_START = (MEM_DELAY > 0) ? 4'(MEM_DELAY - 1) : 4'd0;

   state_t             r_state;
   state_t             w_nextState;
   logic [3:0]         r_cnt;
   logic [3:0]         w_nextCnt;
   logic [31:0]        r_readdata;
   logic [31:0]        r_mem [2**ADDR_W];
   logic [ADDR_W-1:0]  w_word;
   logic               w_misaligned;
   logic               w_busy;
   logic               w_done;
   logic               w_err;
   logic               w_loadData;
   logic               w_memWrite;
   logic               w_unusedAddr;

   assign w_word       = addr[ADDR_W+1:2];
   assign w_misaligned = (addr[1:0] != 2'b00);
   assign w_unusedAddr = ^addr[31:ADDR_W+2];

   // Next state and stall/handshake decode. Alignment errors are flagged only
   // when an access starts, so a held misaligned load gives a single pulse.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_loadData  = 1'b0;
      w_memWrite  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (memwritem) begin
               w_memWrite = 1'b1;
               w_err      = memreadm;
            end else if (memreadm) begin
               if (MEM_DELAY > 0) begin
                  w_busy      = 1'b1;
                  w_nextState = S_WAIT;
                  w_nextCnt   = LP_START;
                  w_loadData  = (LP_START == 4'd0);
               end else begin
                  w_loadData = 1'b1;
               end
            end
            if ((memreadm || memwritem) && w_misaligned) begin
               w_err = 1'b1;
            end
         end
         S_WAIT: begin
            w_err = memwritem;
            if (r_cnt == 4'd0) begin
               w_done      = 1'b1;
               w_nextState = S_IDLE;
            end else if (!memreadm) begin
               w_nextState = S_IDLE;
               w_nextCnt   = 4'd0;
            end else begin
               w_busy     = 1'b1;
               w_nextCnt  = r_cnt - 4'd1;
               w_loadData = (r_cnt == 4'd1);
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextCnt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_readdata <= 32'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         if (w_loadData) begin
            r_readdata <= r_mem[w_word];
         end
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_memWrite) begin
         r_mem[w_word] <= writedata;
      end
   end

   // Gating with reset makes the stall drop the moment reset asserts, even
   // while the stalled pipeline is still holding its load request.
   assign busy     = reset & w_busy;
   assign done     = reset & w_done;
   assign err      = reset & w_err;
   assign readdata = ((MEM_DELAY == 0) && reset && memreadm && !memwritem)
                     ? r_mem[w_word] : r_readdata;

endmodule

// File: tb/tb_data_mem_delay.sv
// Self-checking bench for data_mem_delay: a MEM_DELAY=3 instance for the stall
// protocol and a MEM_DELAY=0 instance for the combinational-read build.
module tb_data_mem_delay;

   localparam int DELAY = 3;

   logic        clk;
   logic        reset;
   logic        memreadm, memwritem;
   logic [31:0] addr, writedata, readdata;
   logic        busy, done, err;

   logic        mr0, mw0;
   logic [31:0] a0, wd0, rd0;
   logic        busy0, done0, err0;

   int          checks;
   int          errors;
   logic [31:0] model  [256];
   logic [31:0] model0 [256];
   logic [31:0] lastRd;

   data_mem_delay #(.MEM_DELAY(DELAY), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .memreadm(memreadm), .memwritem(memwritem),
      .addr(addr), .writedata(writedata), .readdata(readdata),
      .busy(busy), .done(done), .err(err)
   );

   data_mem_delay #(.MEM_DELAY(0), .ADDR_W(8)) dut0 (
      .clk(clk), .reset(reset), .memreadm(mr0), .memwritem(mw0),
      .addr(a0), .writedata(wd0), .readdata(rd0),
      .busy(busy0), .done(done0), .err(err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   // One-cycle store on the main instance.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, output logic errSeen);
      memwritem = 1'b1; addr = a; writedata = d;
      @(negedge clk);
      errSeen = err;
      @(posedge clk); #1;
      memwritem = 1'b0;
   endtask

   // Holds a load until the first non-busy cycle (bounded) and reports what it saw.
   task automatic run_load(input logic [31:0] a, output int busyCycles, output logic doneSeen,
                           output logic [31:0] rd, output int errCycles);
      bit fin = 1'b0;
      busyCycles = 0; doneSeen = 1'b0; rd = 32'hx; errCycles = 0;
      memreadm = 1'b1; addr = a;
      for (int c = 0; c < 40 && !fin; c++) begin
         @(negedge clk);
         if (err) errCycles++;
         if (busy) busyCycles++;
         else begin
            fin = 1'b1; doneSeen = done; rd = readdata;
         end
         @(posedge clk); #1;
      end
      memreadm = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; memreadm = 0; memwritem = 0; addr = 0; writedata = 0;
      mr0 = 0; mw0 = 0; a0 = 0; wd0 = 0;
      #12;
      checks++; if (readdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_readdata got %h want 0", readdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, err} !== 3'b000 || readdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL idle_outputs cycle %0d got busy=%b done=%b err=%b rd=%h want all 0", i, busy, done, err, readdata);
         end
         @(posedge clk); #1;
      end
      lastRd = 32'd0;
   endtask

   task automatic test_store_load;
      logic e; int bc; logic dn; logic [31:0] rd; int ec;
      do_store(32'h10, 32'hDEADBEEF, e); model[widx(32'h10)] = 32'hDEADBEEF;
      checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL store_err got %b want 0", e); end
      do_store(32'h14, 32'h12345678, e); model[widx(32'h14)] = 32'h12345678;
      run_load(32'h10, bc, dn, rd, ec);
      checks++; if (bc != DELAY) begin errors++; $display("[TB] FAIL load_busy_cycles got %0d want %0d", bc, DELAY); end
      checks++; if (dn !== 1'b1) begin errors++; $display("[TB] FAIL load_done got %b want 1", dn); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_data got %h want deadbeef", rd); end
      lastRd = model[widx(32'h10)];
   endtask

   task automatic test_back_to_back;
      int bc1, bc2, ec; logic dn1, dn2; logic [31:0] rd1, rd2;
      run_load(32'h10, bc1, dn1, rd1, ec);
      run_load(32'h14, bc2, dn2, rd2, ec);
      checks++; if (bc1 != DELAY || bc2 != DELAY) begin errors++; $display("[TB] FAIL b2b_busy got %0d/%0d want %0d/%0d", bc1, bc2, DELAY, DELAY); end
      checks++; if (dn1 !== 1'b1 || dn2 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got %b/%b want 1/1", dn1, dn2); end
      checks++; if (rd1 !== model[widx(32'h10)]) begin errors++; $display("[TB] FAIL b2b_data1 got %h want %h", rd1, model[widx(32'h10)]); end
      checks++; if (rd2 !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_data2 got %h want 12345678", rd2); end
      lastRd = rd2;
   endtask

   task automatic test_random;
      logic e; int bc; logic dn; logic [31:0] rd; int ec; logic [31:0] a, d;
      for (int i = 0; i < 6; i++) begin
         a = {22'd0, 8'($urandom_range(8, 255)), 2'b00};
         d = $urandom;
         do_store(a, d, e); model[widx(a)] = d;
         run_load(a, bc, dn, rd, ec);
         checks++;
         if (bc != DELAY || dn !== 1'b1 || rd !== model[widx(a)] || ec != 0) begin
            errors++;
            $display("[TB] FAIL random_load addr %h got busy=%0d done=%b rd=%h errc=%0d want %0d/1/%h/0", a, bc, dn, rd, ec, DELAY, model[widx(a)]);
         end
         lastRd = model[widx(a)];
      end
   endtask

   task automatic test_abort;
      int bc, ec; logic dn; logic [31:0] rd;
      memreadm = 1'b1; addr = 32'h14;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_first_busy got %b want 1", busy); end
      @(posedge clk); #1;
      memreadm = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL abort_drop got busy=%b done=%b want 0/0", busy, done); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || readdata !== lastRd) begin
            errors++;
            $display("[TB] FAIL abort_after cycle %0d got done=%b busy=%b rd=%h want 0/0/%h", i, done, busy, readdata, lastRd);
         end
         @(posedge clk); #1;
      end
      run_load(32'h10, bc, dn, rd, ec);
      checks++; if (bc != DELAY || rd !== model[widx(32'h10)]) begin errors++; $display("[TB] FAIL abort_reload got busy=%0d rd=%h want %0d/%h", bc, rd, DELAY, model[widx(32'h10)]); end
      lastRd = model[widx(32'h10)];
   endtask

   task automatic test_violations;
      bit fin; int errOther; logic dn; logic [31:0] rd; int bc, ec; logic [31:0] misData, e2;
      fin = 1'b0; errOther = 0; dn = 1'b0; rd = 32'hx;
      memreadm = 1'b1; addr = 32'h10;
      for (int c = 0; c < 40 && !fin; c++) begin
         memwritem = (c == 1); writedata = ~model[widx(32'h10)];
         @(negedge clk);
         if (c == 1) begin
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL wait_store_err got %b want 1", err); end
         end else if (err) errOther++;
         if (!busy) begin fin = 1'b1; dn = done; rd = readdata; end
         @(posedge clk); #1;
      end
      memwritem = 1'b0; memreadm = 1'b0;
      checks++; if (errOther != 0) begin errors++; $display("[TB] FAIL wait_store_err_len got %0d extra want 0", errOther); end
      checks++; if (dn !== 1'b1 || rd !== model[widx(32'h10)]) begin errors++; $display("[TB] FAIL wait_store_ignored got done=%b rd=%h want 1/%h", dn, rd, model[widx(32'h10)]); end
      run_load(32'h11, bc, dn, rd, ec);
      checks++; if (ec != 1) begin errors++; $display("[TB] FAIL misalign_err got %0d cycles want 1", ec); end
      checks++; if (rd !== model[widx(32'h10)] || bc != DELAY) begin errors++; $display("[TB] FAIL misalign_data got rd=%h busy=%0d want %h/%0d", rd, bc, model[widx(32'h10)], DELAY); end
      misData = $urandom;
      memreadm = 1'b1; memwritem = 1'b1; addr = 32'h18; writedata = misData;
      @(negedge clk);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rw_conflict got err=%b busy=%b want 1/0", err, busy); end
      @(posedge clk); #1;
      memreadm = 1'b0; memwritem = 1'b0; model[widx(32'h18)] = misData;
      run_load(32'h18, bc, dn, e2, ec);
      checks++; if (e2 !== misData || bc != DELAY) begin errors++; $display("[TB] FAIL rw_conflict_write got rd=%h busy=%0d want %h/%0d", e2, bc, misData, DELAY); end
      lastRd = misData;
   endtask

   task automatic test_reset_mid_wait;
      int bc, ec; logic dn; logic [31:0] rd;
      memreadm = 1'b1; addr = 32'h10;
      @(posedge clk); #3;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midwait_pre_busy got %b want 1", busy); end
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || readdata !== 32'd0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midwait_reset got busy=%b rd=%h done=%b want 0/0/0", busy, readdata, done); end
      memreadm = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      run_load(32'h10, bc, dn, rd, ec);
      checks++; if (bc != DELAY || dn !== 1'b1 || rd !== model[widx(32'h10)]) begin errors++; $display("[TB] FAIL midwait_reload got busy=%0d done=%b rd=%h want %0d/1/%h", bc, dn, rd, DELAY, model[widx(32'h10)]); end
   endtask

   task automatic test_zero_delay;
      logic [31:0] d1, d2;
      d1 = $urandom; d2 = $urandom;
      mw0 = 1'b1; a0 = 32'h10; wd0 = d1;
      @(posedge clk); #1;
      a0 = 32'h14; wd0 = d2;
      @(posedge clk); #1;
      model0[widx(32'h10)] = d1; model0[widx(32'h14)] = d2;
      mw0 = 1'b0; mr0 = 1'b1; a0 = 32'h10;
      #1;
      checks++; if (busy0 !== 1'b0 || rd0 !== model0[widx(32'h10)]) begin errors++; $display("[TB] FAIL zero_delay_read got busy=%b rd=%h want 0/%h", busy0, rd0, model0[widx(32'h10)]); end
      a0 = 32'h14;
      #1;
      checks++; if (rd0 !== model0[widx(32'h14)]) begin errors++; $display("[TB] FAIL zero_delay_comb got rd=%h want %h", rd0, model0[widx(32'h14)]); end
      @(negedge clk);
      checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL zero_delay_flags got busy=%b done=%b want 0/0", busy0, done0); end
      @(posedge clk); #1;
      mr0 = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      test_reset;
      test_store_load;
      test_back_to_back;
      test_random;
      test_abort;
      test_violations;
      test_reset_mid_wait;
      test_zero_delay;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
